// File: rtl/div_sequencer.sv
// div_sequencer: sequences RISC-V M-extension divides (div/divu/rem/remu)
// between the EX stage and a shared divider core. Divide-by-zero and signed
// overflow are answered locally. Every other divide goes through a
// valid/ready issue to the core, a wait for the core result, and a
// registered quotient/remainder select. A flushed op still drains through
// the core. A watchdog bounds the time spent in ISSUE+WAIT.
module div_sequencer #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        stall,
  output logic        done,
  output logic [31:0] result,
  output logic        core_tvalid,
  input  logic        core_tready,
  output logic [31:0] core_dividend,
  output logic [31:0] core_divisor,
  output logic        core_signed,
  input  logic        core_dout_tvalid,
  input  logic [63:0] core_dout_tdata,
  output logic        timeout_err
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        kill_q, kill_d;
  logic [CNT_W-1:0] cnt_q;
  logic [31:0] op_a_q, op_b_q;
  logic        op_signed_q;
  logic        op_rem_q;
  logic [31:0] result_q, result_d;
  logic        result_load;
  logic        timeout_q;

  logic        div_req;
  logic        accept;
  logic        in_core;
  logic        wd_fire;
  logic        kill_now;
  logic        req_signed;
  logic        req_rem;
  logic        div_zero;
  logic        overflow;
  logic [31:0] fast_result;
  logic [31:0] core_sel;

  assign div_req    = req_valid && req_funct3[2];
  assign accept     = (state_q == S_IDLE) && div_req && !flush;
  assign in_core    = (state_q == S_ISSUE) || (state_q == S_WAIT);
  // Fires on the last permitted ISSUE/WAIT cycle (the counter is 0 on the first one).
  assign wd_fire    = in_core && (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
  // A flush arriving in the same cycle as the core result still kills the op.
  assign kill_now   = kill_q || flush;

  assign req_signed = !req_funct3[0];
  assign req_rem    = req_funct3[1];
  assign div_zero   = (req_b == 32'h0);
  assign overflow   = req_signed && (req_a == 32'h8000_0000) && (req_b == 32'hFFFF_FFFF);

  // Locally resolved results: x/0 gives all-ones quotient and the dividend as
  // remainder; INT_MIN/-1 gives INT_MIN quotient and zero remainder.
  assign fast_result = div_zero ? (req_rem ? req_a : 32'hFFFF_FFFF)
                                : (req_rem ? 32'h0 : 32'h8000_0000);

  assign core_sel = op_rem_q ? core_dout_tdata[63:32] : core_dout_tdata[31:0];

  // Next-state, kill tracking and result-load decision.
  always_comb begin
    // NOTE: every signal written here gets a default first, so no path leaves
    // it unassigned and no latch is inferred.
    state_d     = state_q;
    kill_d      = kill_q;
    result_load = 1'b0;
    result_d    = result_q;
    unique case (state_q)
      S_IDLE: begin
        kill_d = 1'b0;
        if (accept) begin
          if (div_zero || overflow) begin
            state_d     = S_DONE;
            result_load = 1'b1;
            result_d    = fast_result;
          end else begin
            state_d = S_ISSUE;
          end
        end
      end
      S_ISSUE, S_WAIT: begin
        if (flush) kill_d = 1'b1;
        if (wd_fire) begin
          if (kill_now) begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d     = S_DONE;
            result_load = 1'b1;
            result_d    = 32'h0;
          end
        end else if (state_q == S_ISSUE) begin
          if (core_tready) state_d = S_WAIT;
        end else if (core_dout_tvalid) begin
          if (kill_now) begin
            state_d = S_IDLE;
            kill_d  = 1'b0;
          end else begin
            state_d     = S_DONE;
            result_load = 1'b1;
            result_d    = core_sel;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        kill_d  = 1'b0;
      end
    endcase
  end

  // State, operand capture, watchdog counter, result and sticky error flag.
  always_ff @(posedge clk) begin
    // NOTE: clocked state uses non-blocking assignments only, so every
    // register samples the pre-edge values regardless of statement order.
    if (reset) begin
      state_q     <= S_IDLE;
      kill_q      <= 1'b0;
      cnt_q       <= '0;
      op_a_q      <= 32'h0;
      op_b_q      <= 32'h0;
      op_signed_q <= 1'b0;
      op_rem_q    <= 1'b0;
      result_q    <= 32'h0;
      timeout_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      kill_q  <= kill_d;
      if (accept) begin
        op_a_q      <= req_a;
        op_b_q      <= req_b;
        op_signed_q <= req_signed;
        op_rem_q    <= req_rem;
        cnt_q       <= '0;
      end else if (in_core) begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
      if (result_load) result_q <= result_d;
      if (wd_fire) timeout_q <= 1'b1;
    end
  end

  assign stall         = div_req && (state_q != S_DONE);
  assign done          = (state_q == S_DONE);
  assign result        = result_q;
  assign core_tvalid   = (state_q == S_ISSUE);
  assign core_dividend = op_a_q;
  assign core_divisor  = op_b_q;
  assign core_signed   = op_signed_q;
  assign timeout_err   = timeout_q;

endmodule

// File: tb/tb_div_sequencer.sv
// Self-checking bench for div_sequencer: table-driven directed vectors,
// hand-written multi-cycle sequences (flush, watchdog, reset, stray core
// strobes) and randomized divides checked against an arithmetic model.
module tb_div_sequencer;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic [2:0]  req_funct3;
  logic [31:0] req_a, req_b;
  logic        flush;
  logic        stall, done;
  logic [31:0] result;
  logic        core_tvalid, core_tready;
  logic [31:0] core_dividend, core_divisor;
  logic        core_signed;
  logic        core_dout_tvalid;
  logic [63:0] core_dout_tdata;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  // Behavioural core controls.
  int core_lat  = 1;
  int core_hold = 0;
  bit core_never = 1'b0;
  bit spurious   = 1'b0;
  int hs_count   = 0;

  div_sequencer #(.TIMEOUT_CYCLES(TO)) dut (
    .clk              (clk),
    .reset            (reset),
    .req_valid        (req_valid),
    .req_funct3       (req_funct3),
    .req_a            (req_a),
    .req_b            (req_b),
    .flush            (flush),
    .stall            (stall),
    .done             (done),
    .result           (result),
    .core_tvalid      (core_tvalid),
    .core_tready      (core_tready),
    .core_dividend    (core_dividend),
    .core_divisor     (core_divisor),
    .core_signed      (core_signed),
    .core_dout_tvalid (core_dout_tvalid),
    .core_dout_tdata  (core_dout_tdata),
    .timeout_err      (timeout_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // RISC-V divide semantics as plain arithmetic: returns {remainder, quotient}.
  function automatic logic [63:0] riscv_divrem(input logic [31:0] a, input logic [31:0] b,
                                               input logic sgn);
    logic [31:0] q, r;
    if (b == 32'h0) return {a, 32'hFFFF_FFFF};
    if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
    if (sgn) begin
      q = 32'($signed(a) / $signed(b));
      r = 32'($signed(a) % $signed(b));
    end else begin
      q = a / b;
      r = a % b;
    end
    return {r, q};
  endfunction

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] qr;
    qr = riscv_divrem(a, b, !f3[0]);
    return f3[1] ? qr[63:32] : qr[31:0];
  endfunction

  // Divider core model: optional tready hold-off, fixed latency after the
  // handshake, one-cycle result strobe. Driven on the falling edge.
  initial begin
    int hc;
    int pend;
    logic [63:0] pdata;
    hc = 0;
    pend = 0;
    pdata = '0;
    core_tready = 1'b0;
    core_dout_tvalid = 1'b0;
    core_dout_tdata = '0;
    forever begin
      @(negedge clk);
      core_dout_tvalid = 1'b0;
      if (reset) begin
        pend = 0;
        hc = 0;
        core_tready = 1'b0;
      end else begin
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            core_dout_tvalid = 1'b1;
            core_dout_tdata  = pdata;
          end
        end
        if (spurious) begin
          core_dout_tvalid = 1'b1;
          core_dout_tdata  = 64'hDEAD_BEEF_CAFE_F00D;
          spurious = 1'b0;
        end
        if (core_tvalid && !core_never) begin
          if (hc < core_hold) begin
            core_tready = 1'b0;
            hc++;
          end else begin
            core_tready = 1'b1;
            hc = 0;
            hs_count++;
            pdata = riscv_divrem(core_dividend, core_divisor, core_signed);
            pend  = core_lat;
          end
        end else begin
          core_tready = 1'b0;
          hc = 0;
        end
      end
    end
  end

  // One complete divide from IDLE: checks stall, operand stability, latency,
  // result, handshake count and the one-cycle done pulse.
  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int lat, input int hold, input logic [31:0] exp, input string name);
    int n;
    int hs0;
    bit fast;
    logic [31:0] prev;
    fast = (b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
    core_lat  = lat;
    core_hold = hold;
    hs0  = hs_count;
    prev = result;
    req_valid = 1'b1; req_funct3 = f3; req_a = a; req_b = b;
    #1;
    check({name, " stall@accept"}, 64'(stall), 64'(1));
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (!done) begin
        check({name, " stall-held"}, 64'(stall), 64'(1));
        check({name, " result-held"}, 64'(result), 64'(prev));
        if (core_tvalid) begin
          check({name, " dividend"}, 64'(core_dividend), 64'(a));
          check({name, " divisor"}, 64'(core_divisor), 64'(b));
          check({name, " signed"}, 64'(core_signed), 64'(!f3[0]));
        end
      end
    end while (!done && n < 100);
    check({name, " latency"}, 64'(n), 64'(fast ? 1 : lat + 2 + hold));
    check({name, " result"}, 64'(result), 64'(exp));
    check({name, " stall@done"}, 64'(stall), 64'(0));
    check({name, " tvalid@done"}, 64'(core_tvalid), 64'(0));
    check({name, " handshakes"}, 64'(hs_count), 64'(fast ? hs0 : hs0 + 1));
    req_valid = 1'b0;
    @(negedge clk);
    check({name, " done-pulse"}, 64'(done), 64'(0));
  endtask

  typedef struct {
    logic [2:0]  f3;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          hold;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vecs[12];

  initial begin
    #2_000_000;
    $display("FAIL global-timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    int n;
    int hs0;
    logic [31:0] prev;
    logic [31:0] ra, rb;
    logic [2:0]  rf;
    int sel;

    vecs[0]  = '{3'b101, 32'd100,        32'd7,          10, 0, 32'd14,         "divu 100/7"};
    vecs[1]  = '{3'b111, 32'd100,        32'd7,          10, 0, 32'd2,          "remu 100/7"};
    vecs[2]  = '{3'b100, 32'd5,          32'd0,          1,  0, 32'hFFFF_FFFF,  "div 5/0"};
    vecs[3]  = '{3'b111, 32'd5,          32'd0,          1,  0, 32'd5,          "remu 5/0"};
    vecs[4]  = '{3'b100, 32'h8000_0000,  32'hFFFF_FFFF,  1,  0, 32'h8000_0000,  "div ovf"};
    vecs[5]  = '{3'b110, 32'h8000_0000,  32'hFFFF_FFFF,  1,  0, 32'h0,          "rem ovf"};
    vecs[6]  = '{3'b100, 32'hFFFF_FFF9,  32'd2,          3,  3, 32'hFFFF_FFFD,  "div -7/2 hold"};
    vecs[7]  = '{3'b110, 32'hFFFF_FFF9,  32'd2,          1,  0, 32'hFFFF_FFFF,  "rem -7/2"};
    vecs[8]  = '{3'b101, 32'hFFFF_FFFF,  32'd2,          4,  1, 32'h7FFF_FFFF,  "divu max/2"};
    vecs[9]  = '{3'b110, 32'hFFFF_FFF9,  32'd0,          1,  0, 32'hFFFF_FFF9,  "rem -7/0"};
    vecs[10] = '{3'b101, 32'h8000_0000,  32'hFFFF_FFFF,  2,  0, 32'h0,          "divu no-ovf"};
    vecs[11] = '{3'b111, 32'h8000_0000,  32'hFFFF_FFFF,  2,  2, 32'h8000_0000,  "remu no-ovf"};

    reset = 1'b1; req_valid = 1'b0; req_funct3 = 3'b000; req_a = '0; req_b = '0; flush = 1'b0;
    repeat (3) @(negedge clk);
    check("reset done", 64'(done), 64'(0));
    check("reset result", 64'(result), 64'(0));
    check("reset tvalid", 64'(core_tvalid), 64'(0));
    check("reset dividend", 64'(core_dividend), 64'(0));
    check("reset timeout", 64'(timeout_err), 64'(0));
    check("reset stall", 64'(stall), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Directed vectors.
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].f3, vecs[i].a, vecs[i].b, vecs[i].lat, vecs[i].hold, vecs[i].exp, vecs[i].name);

    // Mul-class ops are ignored.
    req_valid = 1'b1; req_funct3 = 3'b000; req_a = 32'd9; req_b = 32'd3;
    for (int i = 0; i < 3; i++) begin
      #1 check("mul stall", 64'(stall), 64'(0));
      @(negedge clk);
      check("mul tvalid", 64'(core_tvalid), 64'(0));
      check("mul done", 64'(done), 64'(0));
    end
    req_valid = 1'b0;

    // Flush in IDLE blocks the accept.
    req_valid = 1'b1; req_funct3 = 3'b101; req_a = 32'd10; req_b = 32'd3; flush = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0;
    check("idle-flush tvalid", 64'(core_tvalid), 64'(0));
    check("idle-flush done", 64'(done), 64'(0));
    @(negedge clk);
    check("idle-flush tvalid2", 64'(core_tvalid), 64'(0));

    // Stray core strobe outside WAIT is ignored.
    prev = result;
    spurious = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("stray done", 64'(done), 64'(0));
      check("stray result", 64'(result), 64'(prev));
    end

    // Flush in WAIT, then a new divu that waits for the stale result.
    do_op(3'b101, 32'd100, 32'd7, 2, 0, 32'd14, "pre-flush");
    prev = result;
    hs0  = hs_count;
    core_lat = 8; core_hold = 0;
    req_valid = 1'b1; req_funct3 = 3'b101; req_a = 32'd1000; req_b = 32'd10;
    @(negedge clk);   // n=1, ISSUE
    @(negedge clk);   // n=2, WAIT
    flush = 1'b1; req_valid = 1'b0;
    @(negedge clk);   // n=3
    flush = 1'b0;
    core_lat = 2;
    req_valid = 1'b1; req_funct3 = 3'b101; req_a = 32'd81; req_b = 32'd9;
    n = 3;
    #1 check("killed stall", 64'(stall), 64'(1));
    while (!done && n < 60) begin
      @(negedge clk);
      n++;
      if (!done) begin
        check("killed result-held", 64'(result), 64'(prev));
        check("killed stall-held", 64'(stall), 64'(1));
      end
    end
    check("post-flush done-cycle", 64'(n), 64'(14));
    check("post-flush result", 64'(result), 64'(9));
    check("post-flush handshakes", 64'(hs_count), 64'(hs0 + 2));
    req_valid = 1'b0;
    @(negedge clk);

    // Randomized divides against the arithmetic model.
    for (int i = 0; i < 40; i++) begin
      rf  = 3'(4 + $urandom_range(0, 3));
      sel = $urandom_range(0, 9);
      ra  = $urandom();
      rb  = $urandom();
      if (sel == 0) rb = 32'h0;
      else if (sel == 1) begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
      else if (sel == 2) begin ra = 32'($urandom_range(0, 200)) - 32'd100; rb = 32'($urandom_range(1, 12)); end
      do_op(rf, ra, rb, $urandom_range(1, 6), $urandom_range(0, 2), ref_result(rf, ra, rb), "rand");
    end

    // Watchdog: core never accepts.
    core_never = 1'b1;
    req_valid = 1'b1; req_funct3 = 3'b100; req_a = 32'd50; req_b = 32'd5;
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == TO) begin
        check("wd tvalid-before", 64'(core_tvalid), 64'(1));
        check("wd err-before", 64'(timeout_err), 64'(0));
      end
    end while (!done && n < 40);
    check("wd done-cycle", 64'(n), 64'(TO + 1));
    check("wd result", 64'(result), 64'(0));
    check("wd err", 64'(timeout_err), 64'(1));
    check("wd tvalid-dropped", 64'(core_tvalid), 64'(0));
    req_valid = 1'b0;
    core_never = 1'b0;
    @(negedge clk);
    do_op(3'b101, 32'd100, 32'd7, 3, 0, 32'd14, "after-wd");
    check("wd sticky", 64'(timeout_err), 64'(1));

    // Reset in the middle of WAIT.
    core_lat = 10; core_hold = 0;
    req_valid = 1'b1; req_funct3 = 3'b101; req_a = 32'd100; req_b = 32'd7;
    repeat (3) @(negedge clk);
    reset = 1'b1; req_valid = 1'b0;
    @(negedge clk);
    check("rst-wait done", 64'(done), 64'(0));
    check("rst-wait result", 64'(result), 64'(0));
    check("rst-wait tvalid", 64'(core_tvalid), 64'(0));
    check("rst-wait dividend", 64'(core_dividend), 64'(0));
    check("rst-wait divisor", 64'(core_divisor), 64'(0));
    check("rst-wait signed", 64'(core_signed), 64'(0));
    check("rst-wait timeout", 64'(timeout_err), 64'(0));
    check("rst-wait stall", 64'(stall), 64'(0));
    @(negedge clk);
    reset = 1'b0;
    repeat (12) @(negedge clk);
    check("rst-wait no stray done", 64'(done), 64'(0));
    do_op(3'b111, 32'd100, 32'd7, 2, 1, 32'd2, "after-reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
